// File: rtl/ftdnn_actbuf_feeder.sv
// Activation-buffer feeder: reads single-width activation words from the
// activation memory, packs each issue-order pair into one double-width beat
// and streams bursts of up to BURST_LEN beats whenever the array requests.
module ftdnn_actbuf_feeder #(
  parameter int unsigned DATA_LEN  = 64,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LEN_W     = 12
) (
  input  logic                  clk_l,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic [DATA_LEN-1:0]   mem_rd_data,
  input  logic                  actbuf_wr_req,
  output logic                  actbuf_wr_vld,
  output logic [2*DATA_LEN-1:0] actbuf_wr_data
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned CNT_W  = BEAT_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    BURST,
    DRAIN,
    FIN
  } state_e;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]      remain_q, remain_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  drain_q, drain_d;
  logic                  last_rd;

  // Read-return pipeline and beat packing registers.
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_odd_q, rd_odd_d;
  logic [DATA_LEN-1:0]   lo_q, lo_d;
  logic                  wr_vld_q, wr_vld_d;
  logic [2*DATA_LEN-1:0] wr_data_q, wr_data_d;

  assign busy           = busy_q;
  assign done           = (state_q == FIN);
  assign mem_rd_en      = (state_q == BURST);
  assign mem_rd_addr    = addr_q;
  assign actbuf_wr_vld  = wr_vld_q;
  assign actbuf_wr_data = wr_data_q;

  // Next-state logic for the job sequencer and its counters.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    beats_d  = beats_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    last_rd  = (cnt_q == (({1'b0, beats_q}) << 1) - CNT_W'(1));

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_len != '0) begin
            addr_d   = cfg_base;
            remain_d = cfg_len;
            busy_d   = 1'b1;
            state_d  = WAIT_REQ;
          end else begin
            state_d = FIN;
          end
        end
      end
      WAIT_REQ: begin
        if (actbuf_wr_req) begin
          beats_d = (32'(remain_q) >= BURST_LEN) ? BEAT_W'(BURST_LEN)
                                                 : BEAT_W'(remain_q);
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q + CNT_W'(1);
        // Pair split follows issue order: every second read closes a beat.
        if (cnt_q[0] && (remain_q != '0)) begin
          remain_d = remain_q - LEN_W'(1);
        end
        if (last_rd) begin
          drain_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = (remain_q == '0) ? FIN : WAIT_REQ;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next-state logic for read-return tracking and beat assembly.
  always_comb begin
    rd_vld_d  = mem_rd_en;
    rd_odd_d  = cnt_q[0];
    lo_d      = lo_q;
    wr_vld_d  = 1'b0;
    wr_data_d = wr_data_q;
    if (rd_vld_q && !rd_odd_q) begin
      lo_d = mem_rd_data;
    end
    if (rd_vld_q && rd_odd_q) begin
      wr_vld_d  = 1'b1;
      wr_data_d = {mem_rd_data, lo_q};
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk_l) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
      beats_q  <= '0;
      cnt_q    <= '0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      beats_q  <= beats_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
    end
  end

  // Packing registers; clearing rd_vld_q drops any read still in flight.
  always_ff @(posedge clk_l) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_odd_q  <= 1'b0;
      lo_q      <= '0;
      wr_vld_q  <= 1'b0;
      wr_data_q <= '0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_odd_q  <= rd_odd_d;
      lo_q      <= lo_d;
      wr_vld_q  <= wr_vld_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_ftdnn_actbuf_feeder.sv
// Bench for ftdnn_actbuf_feeder: table of jobs with hand-computed beats,
// randomized jobs against a pair/burst model, and hand-written corner cases.
module tb_ftdnn_actbuf_feeder;

  localparam int BL = 4;

  logic clk_l = 1'b0;
  always #5 clk_l = ~clk_l;

  // Main instance (ADDR_W=12)
  logic        rst, cfg_start, busy, done, mem_rd_en, actbuf_wr_req, actbuf_wr_vld;
  logic [11:0] cfg_base, cfg_len, mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic [15:0] actbuf_wr_data;

  // Wrap instance (ADDR_W=4)
  logic        w_cfg_start, w_busy, w_done, w_mem_rd_en, w_req, w_vld;
  logic [3:0]  w_cfg_base, w_mem_rd_addr;
  logic [11:0] w_cfg_len;
  logic [7:0]  w_mem_rd_data;
  logic [15:0] w_data;

  ftdnn_actbuf_feeder #(.DATA_LEN(8), .BURST_LEN(4), .ADDR_W(12), .LEN_W(12)) dut (
    .clk_l(clk_l), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .actbuf_wr_req(actbuf_wr_req), .actbuf_wr_vld(actbuf_wr_vld),
    .actbuf_wr_data(actbuf_wr_data)
  );

  ftdnn_actbuf_feeder #(.DATA_LEN(8), .BURST_LEN(4), .ADDR_W(4), .LEN_W(12)) dut_w (
    .clk_l(clk_l), .rst(rst), .cfg_start(w_cfg_start), .cfg_base(w_cfg_base),
    .cfg_len(w_cfg_len), .busy(w_busy), .done(w_done), .mem_rd_en(w_mem_rd_en),
    .mem_rd_addr(w_mem_rd_addr), .mem_rd_data(w_mem_rd_data),
    .actbuf_wr_req(w_req), .actbuf_wr_vld(w_vld), .actbuf_wr_data(w_data)
  );

  // Activation memory: mem[a] = a[7:0], one-cycle read latency.
  always @(posedge clk_l) begin
    if (mem_rd_en === 1'b1) mem_rd_data <= mem_rd_addr[7:0];
    else                    mem_rd_data <= 8'hEE;
    if (w_mem_rd_en === 1'b1) w_mem_rd_data <= {4'h0, w_mem_rd_addr};
    else                      w_mem_rd_data <= 8'hEE;
  end

  int ncyc = 0;
  always @(posedge clk_l) ncyc <= ncyc + 1;

  int nvec = 0;
  int nmis = 0;

  logic [11:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [15:0] beat_q[$];
  int          beat_cyc_q[$];
  int          done_cyc_q[$];
  bit          busy_hist[0:32767];
  logic [3:0]  w_rd_q[$];
  logic [15:0] w_beat_q[$];
  int          w_done_n = 0;

  // Output monitors, sampled on the falling edge.
  always @(negedge clk_l) begin
    if (mem_rd_en === 1'b1) begin
      rd_addr_q.push_back(mem_rd_addr);
      rd_cyc_q.push_back(ncyc);
    end
    if (actbuf_wr_vld === 1'b1) begin
      beat_q.push_back(actbuf_wr_data);
      beat_cyc_q.push_back(ncyc);
    end
    if (done === 1'b1) done_cyc_q.push_back(ncyc);
    if (ncyc < 32768) busy_hist[ncyc] = (busy === 1'b1);
    if (w_mem_rd_en === 1'b1) w_rd_q.push_back(w_mem_rd_addr);
    if (w_vld === 1'b1) w_beat_q.push_back(w_data);
    if (w_done === 1'b1) w_done_n++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic clear_mon();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    beat_q.delete();
    beat_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic step();
    @(negedge clk_l);
    #1;
  endtask

  // Run one job and compare against the pair/burst model.
  // req_delay < 0: request held high from start; else rises req_delay cycles after start.
  task automatic do_job(input logic [11:0] base, input logic [11:0] len,
                        input int req_delay, input bit rnd, input bit mid);
    logic [15:0] exp_beats[$];
    logic [11:0] exp_addr[$];
    int          exp_runs[$];
    int          runs[$];
    int          run_start[$];
    int          run_end[$];
    logic [11:0] a;
    int          rem, b, t0, k, exp_first;

    for (int i = 0; i < 2 * int'(len); i++) exp_addr.push_back(base + 12'(i));
    for (int i = 0; i < int'(len); i++) begin
      a = base + 12'(2 * i);
      exp_beats.push_back({8'(a + 12'd1), a[7:0]});
    end
    rem = int'(len);
    while (rem > 0) begin
      b = (rem < BL) ? rem : BL;
      exp_runs.push_back(2 * b);
      rem -= b;
    end

    clear_mon();
    step();
    actbuf_wr_req = rnd ? 1'($urandom_range(0, 1)) : (req_delay < 0);
    cfg_base  = base;
    cfg_len   = len;
    cfg_start = 1'b1;
    t0 = ncyc;
    k = 0;
    while (done_cyc_q.size() == 0 && k < 3000) begin
      step();
      k++;
      cfg_start = mid && (k == 6);
      if (mid && k == 6) begin
        cfg_base = 12'h555;
        cfg_len  = 12'd2;
      end
      if (rnd) actbuf_wr_req = ($urandom_range(0, 3) != 0);
      else if (req_delay >= 0 && k == req_delay) actbuf_wr_req = 1'b1;
    end
    cfg_start = 1'b0;
    step();
    step();

    chk("job_done_seen", 32'(done_cyc_q.size() > 0), 32'd1);
    chk("done_count", done_cyc_q.size(), 1);
    chk("busy_after_start", 32'(busy_hist[t0 + 1]), 32'd1);
    chk("beat_count", beat_q.size(), exp_beats.size());
    if (beat_q.size() == exp_beats.size())
      for (int i = 0; i < beat_q.size(); i++) chk("beat_data", beat_q[i], exp_beats[i]);
    chk("read_count", rd_addr_q.size(), exp_addr.size());
    if (rd_addr_q.size() == exp_addr.size()) begin
      for (int i = 0; i < rd_addr_q.size(); i++) chk("read_addr", rd_addr_q[i], exp_addr[i]);
      for (int i = 0; i < beat_cyc_q.size() && 2 * i + 1 < rd_cyc_q.size(); i++)
        chk("beat_latency", beat_cyc_q[i], rd_cyc_q[2 * i + 1] + 2);
    end

    for (int i = 0; i < rd_cyc_q.size(); i++) begin
      if (i == 0 || rd_cyc_q[i] != rd_cyc_q[i - 1] + 1) begin
        runs.push_back(1);
        run_start.push_back(rd_cyc_q[i]);
        run_end.push_back(rd_cyc_q[i]);
      end else begin
        runs[runs.size() - 1] = runs[runs.size() - 1] + 1;
        run_end[run_end.size() - 1] = rd_cyc_q[i];
      end
    end
    chk("burst_count", runs.size(), exp_runs.size());
    if (runs.size() == exp_runs.size())
      for (int i = 0; i < runs.size(); i++) chk("burst_len", runs[i], exp_runs[i]);

    if (beat_cyc_q.size() > 0 && done_cyc_q.size() > 0) begin
      chk("done_after_last_beat", done_cyc_q[0], beat_cyc_q[beat_cyc_q.size() - 1] + 1);
      chk("busy_cleared", 32'(busy_hist[done_cyc_q[0] + 1]), 32'd0);
    end
    if (!rnd && rd_cyc_q.size() > 0) begin
      exp_first = (req_delay < 0) ? t0 + 2 : t0 + req_delay + 1;
      chk("first_read_cycle", rd_cyc_q[0], exp_first);
      if (req_delay < 0)
        for (int i = 1; i < run_start.size(); i++)
          chk("burst_gap", run_start[i] - run_end[i - 1], 4);
    end
  endtask

  typedef struct {
    logic [11:0] base;
    logic [11:0] len;
    int          req_delay;
    bit          mid;
    int          exp_nbeats;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_reads;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    int nbusy;

    tbl[0] = '{12'h010, 12'd6, -1, 1'b0, 6, 16'h1110, 16'h1B1A, 12};
    tbl[1] = '{12'h010, 12'd6, 20, 1'b0, 6, 16'h1110, 16'h1B1A, 12};
    tbl[2] = '{12'h0FF, 12'd2, -1, 1'b0, 2, 16'h00FF, 16'h0201, 4};
    tbl[3] = '{12'hFFE, 12'd5, -1, 1'b0, 5, 16'hFFFE, 16'h0706, 10};
    tbl[4] = '{12'h010, 12'd6, -1, 1'b1, 6, 16'h1110, 16'h1B1A, 12};
    tbl[5] = '{12'h123, 12'd4, -1, 1'b0, 4, 16'h2423, 16'h2A29, 8};
    tbl[6] = '{12'h200, 12'd9, -1, 1'b0, 9, 16'h0100, 16'h1110, 18};

    rst = 1'b1;
    cfg_start = 1'b0; cfg_base = '0; cfg_len = '0; actbuf_wr_req = 1'b0;
    w_cfg_start = 1'b0; w_cfg_base = '0; w_cfg_len = '0; w_req = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_vld", 32'(actbuf_wr_vld), 32'd0);
    chk("rst_data", 32'(actbuf_wr_data), 32'd0);

    // Table-driven jobs
    for (int i = 0; i < 7; i++) begin
      do_job(tbl[i].base, tbl[i].len, tbl[i].req_delay, 1'b0, tbl[i].mid);
      chk("tbl_nbeats", beat_q.size(), tbl[i].exp_nbeats);
      if (beat_q.size() > 0) begin
        chk("tbl_first_beat", beat_q[0], tbl[i].exp_first);
        chk("tbl_last_beat", beat_q[beat_q.size() - 1], tbl[i].exp_last);
      end
      chk("tbl_reads", rd_addr_q.size(), tbl[i].exp_reads);
    end

    // Zero length, start coincident with done, start one cycle after done
    clear_mon();
    step();
    actbuf_wr_req = 1'b0;
    cfg_base = 12'h040; cfg_len = 12'd0; cfg_start = 1'b1;
    t = ncyc;
    step();
    chk("zero_done_t1", 32'(done), 32'd1);
    chk("zero_busy_t1", 32'(busy), 32'd0);
    cfg_len = 12'd3;
    step();
    chk("coincident_start_done", 32'(done), 32'd0);
    chk("coincident_start_busy", 32'(busy), 32'd0);
    cfg_len = 12'd0;
    step();
    chk("start_after_done", 32'(done), 32'd1);
    cfg_start = 1'b0;
    repeat (6) step();
    nbusy = 0;
    for (int c = t; c < t + 9; c++) if (busy_hist[c]) nbusy++;
    chk("zero_busy_never", nbusy, 0);
    chk("zero_reads", rd_addr_q.size(), 0);
    chk("zero_done_count", done_cyc_q.size(), 2);

    // Reset on the second beat's odd read
    clear_mon();
    step();
    actbuf_wr_req = 1'b1;
    cfg_base = 12'h020; cfg_len = 12'd8; cfg_start = 1'b1;
    t = ncyc;
    step();
    cfg_start = 1'b0;
    while (ncyc < t + 5) step();
    chk("rst_mid_addr", 32'(mem_rd_addr), 32'h023);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_mid_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_mid_vld", 32'(actbuf_wr_vld), 32'd0);
    chk("rst_mid_data", 32'(actbuf_wr_data), 32'd0);
    repeat (10) step();
    chk("rst_mid_beats", beat_q.size(), 1);
    if (beat_q.size() > 0) chk("rst_mid_beat0", beat_q[0], 16'h2120);
    chk("rst_mid_reads", rd_addr_q.size(), 4);
    do_job(12'h030, 12'd3, -1, 1'b0, 1'b0);

    // Address wrap with odd base on the 4-bit instance
    step();
    w_req = 1'b1; w_cfg_base = 4'hF; w_cfg_len = 12'd1; w_cfg_start = 1'b1;
    step();
    w_cfg_start = 1'b0;
    for (int k = 0; k < 100 && w_done_n == 0; k++) step();
    step();
    chk("wrap_done", w_done_n, 1);
    chk("wrap_reads", w_rd_q.size(), 2);
    if (w_rd_q.size() == 2) begin
      chk("wrap_addr0", 32'(w_rd_q[0]), 32'hF);
      chk("wrap_addr1", 32'(w_rd_q[1]), 32'h0);
    end
    chk("wrap_beats", w_beat_q.size(), 1);
    if (w_beat_q.size() > 0) chk("wrap_beat", w_beat_q[0], 16'h000F);

    // Randomized jobs with a randomly toggling request
    for (int j = 0; j < 10; j++) begin
      repeat ($urandom_range(0, 3)) step();
      do_job(12'($urandom), 12'($urandom_range(1, 11)), -1, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
